pid_servo_ctrl: RTL and testbench

Parametrised, pipelined signed PID controller running on the 20 Hz sample clock. Converts a distance measurement plus a runtime setpoint into a clamped servo PWM duty value, with deadband, conditional-integration anti-windup, derivative-kick suppression and a measurement-loss timeout. It sits between the distance sensor front end and the PWM generator and the seven-segment duty display.

---
 rtl/pid_pkg.sv | 12 +
 rtl/pid_sat_map.sv | 29 ++
 rtl/pid_servo_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_pid_servo_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared accumulator type and clamp helper for the PID servo loop
package pid_pkg;

  localparam int PID_ACC_W = 20;

  typedef logic signed [PID_ACC_W-1:0] acc_t;

  function automatic int saturate(input int x, input int lo, input int hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

endpackage

// File: rtl/pid_sat_map.sv
// rtl/pid_sat_map.sv - output stage: gain shift, neutral offset, duty clamp and saturation flags
module pid_sat_map
  import pid_pkg::*;
#(
  parameter int ACC_W      = PID_ACC_W,
  parameter int DUTY_W     = 9,
  parameter int GAIN_SHIFT = 2,
  parameter int DUTY_MIN   = 26,
  parameter int DUTY_MID   = 76,
  parameter int DUTY_MAX   = 126
) (
  input  logic signed [ACC_W+1:0] sum,
  output logic [DUTY_W-1:0]       duty,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  int u;
  int raw;

  always_comb begin
    u      = int'(sum) >>> GAIN_SHIFT;
    raw    = DUTY_MID + u;
    sat_hi = (raw > DUTY_MAX);
    sat_lo = (raw < DUTY_MIN);
    duty   = DUTY_W'(saturate(raw, DUTY_MIN, DUTY_MAX));
  end

endmodule

// File: rtl/pid_servo_ctrl.sv
// rtl/pid_servo_ctrl.sv - pipelined PID servo loop, sample in to duty out in three cycles
// Define PID_DERIV_FILTER_EN to pass the derivative term through a first-order IIR.
module pid_servo_ctrl
  import pid_pkg::*;
#(
  parameter int MEAS_W      = 6,
  parameter int ACC_W       = PID_ACC_W,
  parameter int DUTY_W      = 9,
  parameter int KP          = 8,
  parameter int KI          = 1,
  parameter int KD          = 4,
  parameter int GAIN_SHIFT  = 2,
  parameter int I_LIM       = 400,
  parameter int DEADBAND    = 1,
  parameter int DUTY_MIN    = 26,
  parameter int DUTY_MID    = 76,
  parameter int DUTY_MAX    = 126,
  parameter int TIMEOUT_CYC = 10,
  parameter int DF_SHIFT    = 2
) (
  input  logic              clk_20Hz,
  input  logic              rst,
  input  logic              enable,
  input  logic [MEAS_W-1:0] setpoint,
  input  logic [MEAS_W-1:0] meas,
  input  logic              meas_valid,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              fault
);

  localparam int EW    = MEAS_W + 1;
  localparam int DW    = MEAS_W + 2;
  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  if (DF_SHIFT < 0 || DF_SHIFT >= ACC_W || GAIN_SHIFT < 0) begin : g_param_check
    $error("pid_servo_ctrl: shift parameter out of range");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fault_q, fault_d;
  logic                    armed_q, armed_d;
  logic signed [EW-1:0]    e_prev_q, e_prev_d;
  logic                    v1_q, v1_d;
  logic signed [EW-1:0]    e1_q, e1_d;
  logic signed [DW-1:0]    de1_q, de1_d;
  logic                    v2_q, v2_d;
  logic signed [ACC_W-1:0] p2_q, p2_d;
  logic signed [ACC_W-1:0] d2_q, d2_d;
  logic signed [ACC_W-1:0] i_q, i_d;
  logic                    v3_q, v3_d;
  logic signed [SW-1:0]    s3_q, s3_d;
  logic [DUTY_W-1:0]       duty_q, duty_d;
  logic                    dv_q, dv_d;
  logic                    sat_hi_q, sat_hi_d;
  logic                    sat_lo_q, sat_lo_d;
`ifdef PID_DERIV_FILTER_EN
  logic signed [ACC_W-1:0] df_q, df_d;
  int                      df_in;
`endif

  logic              accept;
  logic              i_hold;
  logic [DUTY_W-1:0] map_duty;
  logic              map_hi;
  logic              map_lo;
  int                e_in, de_in, e2, p_in, d_raw, d_in, i_in, i_upd, s_in;

  assign accept = enable & meas_valid;

  // Datapath arithmetic runs in 32-bit int; the registers below hold the narrowed results.
  always_comb begin
    e_in = int'(setpoint) - int'(meas);
    if (e_in >= -DEADBAND && e_in <= DEADBAND) e_in = 0;
    de_in  = armed_q ? 0 : e_in - int'(e_prev_q);
    e2     = int'(e1_q);
    p_in   = KP * e2;
    d_raw  = KD * int'(de1_q);
    i_in   = int'(i_q);
    // Conditional integration: never push further into a rail the output is already on.
    i_hold = (e2 == 0) || (sat_hi_q && e2 > 0) || (sat_lo_q && e2 < 0);
    i_upd  = i_hold ? i_in : saturate(i_in + KI * e2, -I_LIM, I_LIM);
`ifdef PID_DERIV_FILTER_EN
    df_in  = int'(df_q) + ((d_raw - int'(df_q)) >>> DF_SHIFT);
    d_in   = df_in;
`else
    d_in   = d_raw;
`endif
    s_in   = int'(p2_q) + int'(i_q) + int'(d2_q);
  end

  pid_sat_map #(
    .ACC_W      (ACC_W),
    .DUTY_W     (DUTY_W),
    .GAIN_SHIFT (GAIN_SHIFT),
    .DUTY_MIN   (DUTY_MIN),
    .DUTY_MID   (DUTY_MID),
    .DUTY_MAX   (DUTY_MAX)
  ) u_sat_map (
    .sum    (s3_q),
    .duty   (map_duty),
    .sat_hi (map_hi),
    .sat_lo (map_lo)
  );

  always_comb begin
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    armed_d  = armed_q;
    e_prev_d = e_prev_q;
    v1_d     = 1'b0;
    e1_d     = e1_q;
    de1_d    = de1_q;
    v2_d     = 1'b0;
    p2_d     = p2_q;
    d2_d     = d2_q;
    i_d      = i_q;
    v3_d     = 1'b0;
    s3_d     = s3_q;
    dv_d     = 1'b0;
    duty_d   = duty_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
`ifdef PID_DERIV_FILTER_EN
    df_d     = df_q;
`endif
    if (!enable) begin
      i_d      = '0;
      duty_d   = DUTY_W'(DUTY_MID);
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
      armed_d  = 1'b1;
      cnt_d    = '0;
      fault_d  = 1'b0;
`ifdef PID_DERIV_FILTER_EN
      df_d     = '0;
`endif
    end else begin
      v1_d = accept;
      if (accept) begin
        e1_d     = EW'(e_in);
        de1_d    = DW'(de_in);
        e_prev_d = EW'(e_in);
        armed_d  = 1'b0;
      end
      v2_d = v1_q;
      if (v1_q) begin
        p2_d = ACC_W'(p_in);
        d2_d = ACC_W'(d_in);
        i_d  = ACC_W'(i_upd);
`ifdef PID_DERIV_FILTER_EN
        df_d = ACC_W'(df_in);
`endif
      end
      v3_d = v2_q;
      if (v2_q) s3_d = SW'(s_in);
      dv_d = v3_q;
      if (v3_q) begin
        duty_d   = map_duty;
        sat_hi_d = map_hi;
        sat_lo_d = map_lo;
      end
      // A sample arriving on the threshold cycle wins over the timeout.
      if (accept) begin
        cnt_d   = '0;
        fault_d = 1'b0;
      end else if (int'(cnt_q) >= TIMEOUT_CYC - 1) begin
        cnt_d    = CNT_W'(TIMEOUT_CYC);
        fault_d  = 1'b1;
        armed_d  = 1'b1;
        v2_d     = 1'b0;
        v3_d     = 1'b0;
        dv_d     = 1'b0;
        i_d      = '0;
        duty_d   = DUTY_W'(DUTY_MID);
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
`ifdef PID_DERIV_FILTER_EN
        df_d     = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_20Hz) begin
    if (rst) begin
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      armed_q  <= 1'b1;
      e_prev_q <= '0;
      v1_q     <= 1'b0;
      e1_q     <= '0;
      de1_q    <= '0;
      v2_q     <= 1'b0;
      p2_q     <= '0;
      d2_q     <= '0;
      i_q      <= '0;
      v3_q     <= 1'b0;
      s3_q     <= '0;
      duty_q   <= DUTY_W'(DUTY_MID);
      dv_q     <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
      df_q     <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      armed_q  <= armed_d;
      e_prev_q <= e_prev_d;
      v1_q     <= v1_d;
      e1_q     <= e1_d;
      de1_q    <= de1_d;
      v2_q     <= v2_d;
      p2_q     <= p2_d;
      d2_q     <= d2_d;
      i_q      <= i_d;
      v3_q     <= v3_d;
      s3_q     <= s3_d;
      duty_q   <= duty_d;
      dv_q     <= dv_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
`ifdef PID_DERIV_FILTER_EN
      df_q     <= df_d;
`endif
    end
  end

  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pid_servo_ctrl.sv
// tb/tb_pid_servo_ctrl.sv - randomized bench for pid_servo_ctrl against a sample-level PID model
module tb_pid_servo_ctrl;

  localparam int KP = 8, KI = 1, KD = 4, GS = 2, ILIM = 400, DB = 1;
  localparam int DMIN = 26, DMID = 76, DMAX = 126, TO = 10, DFS = 2;

  logic       clk_20Hz = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       meas_valid = 1'b0;
  logic [5:0] setpoint = '0;
  logic [5:0] meas = '0;
  logic [8:0] duty;
  logic       duty_valid, sat_hi, sat_lo, fault;

  pid_servo_ctrl dut (
    .clk_20Hz   (clk_20Hz),
    .rst        (rst),
    .enable     (enable),
    .setpoint   (setpoint),
    .meas       (meas),
    .meas_valid (meas_valid),
    .duty       (duty),
    .duty_valid (duty_valid),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .fault      (fault)
  );

  always #5 clk_20Hz = ~clk_20Hz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Each accepted sample is a record: its error terms, when it integrates, when it appears.
  typedef struct {
    int e;
    int de;
    int s2;
    int oc;
    int duty;
    bit hi;
    bit lo;
  } item_t;

  item_t pq[$];
  item_t it;
  int    cyc = 0;
  int    m_i, m_df, m_eprev, m_cnt, m_duty;
  int    e, de, d, s, raw;
  bit    m_armed, m_fault, m_dv, m_hi, m_lo;
  bit    chk_on = 1'b0;

  always @(posedge clk_20Hz) begin : model
    cyc++;
    if (rst) begin
      pq.delete();
      m_i = 0; m_df = 0; m_eprev = 0; m_cnt = 0; m_duty = DMID;
      m_armed = 1; m_fault = 0; m_dv = 0; m_hi = 0; m_lo = 0;
    end else if (!enable) begin
      pq.delete();
      m_i = 0; m_df = 0; m_cnt = 0; m_duty = DMID;
      m_armed = 1; m_fault = 0; m_dv = 0; m_hi = 0; m_lo = 0;
    end else begin
      for (int i = 0; i < pq.size(); i++) begin
        if (pq[i].s2 == cyc) begin
          it = pq[i];
          if (!(it.e == 0 || (m_hi && it.e > 0) || (m_lo && it.e < 0)))
            m_i = clampi(m_i + KI * it.e, -ILIM, ILIM);
`ifdef PID_DERIV_FILTER_EN
          m_df = m_df + ((KD * it.de - m_df) >>> DFS);
          d = m_df;
`else
          d = KD * it.de;
`endif
          s = (KP * it.e + m_i + d) >>> GS;
          raw = DMID + s;
          it.duty = clampi(raw, DMIN, DMAX);
          it.hi = (raw > DMAX);
          it.lo = (raw < DMIN);
          pq[i] = it;
        end
      end
      m_dv = 0;
      if (pq.size() > 0 && pq[0].oc == cyc) begin
        m_duty = pq[0].duty; m_hi = pq[0].hi; m_lo = pq[0].lo; m_dv = 1;
        void'(pq.pop_front());
      end
      if (meas_valid) begin
        e = int'(setpoint) - int'(meas);
        if (e >= -DB && e <= DB) e = 0;
        de = m_armed ? 0 : e - m_eprev;
        m_eprev = e;
        m_armed = 0;
        it = '{e: e, de: de, s2: cyc + 1, oc: cyc + 3, duty: 0, hi: 0, lo: 0};
        pq.push_back(it);
        m_cnt = 0;
        m_fault = 0;
      end else if (m_cnt + 1 >= TO) begin
        m_cnt = TO; m_fault = 1; pq.delete(); m_i = 0; m_df = 0;
        m_duty = DMID; m_hi = 0; m_lo = 0; m_dv = 0; m_armed = 1;
      end else begin
        m_cnt++;
      end
    end
    chk_on = 1'b1;
  end

  always @(negedge clk_20Hz) begin
    if (chk_on) begin
      check("duty", duty, m_duty);
      check("duty_valid", duty_valid, m_dv);
      check("sat_hi", sat_hi, m_hi);
      check("sat_lo", sat_lo, m_lo);
      check("fault", fault, m_fault);
    end
  end

  task automatic drive(input bit en, input bit mv, input int sp, input int ms);
    @(negedge clk_20Hz);
    enable = en; meas_valid = mv; setpoint = 6'(sp); meas = 6'(ms);
  endtask

  task automatic sample_and_wait(input int sp, input int ms);
    drive(1, 1, sp, ms);
    repeat (3) drive(1, 0, sp, ms);
    @(negedge clk_20Hz);
  endtask

  bit saw_dv;
  int gap;
  int r;

  initial begin
    repeat (2) @(negedge clk_20Hz);
    check("lit_rst_duty", duty, 76);
    check("lit_rst_dv", duty_valid, 0);
    check("lit_rst_fault", fault, 0);
    rst = 1'b0;

    sample_and_wait(35, 25);
    check("lit_first_duty", duty, 98);
    check("lit_first_dv", duty_valid, 1);
    sample_and_wait(35, 25);
    check("lit_repeat_duty", duty, 101);
    sample_and_wait(35, 0);
    check("lit_sat_hi_duty", duty, 126);
    check("lit_sat_hi_flag", sat_hi, 1);
    sample_and_wait(35, 0);
    check("lit_windup_duty", duty, 126);
    sample_and_wait(35, 34);
    check("lit_windup_held_i", duty, 54);
    sample_and_wait(35, 34);
    check("lit_deadband_duty", duty, 89);

    repeat (12) drive(1, 0, 0, 0);
    check("lit_timeout_fault", fault, 1);
    check("lit_timeout_duty", duty, 76);
    drive(1, 1, 35, 63);
    drive(1, 0, 35, 63);
    check("lit_fault_clear", fault, 0);
    repeat (2) drive(1, 0, 35, 63);
    @(negedge clk_20Hz);
    check("lit_sat_lo_duty", duty, 26);
    check("lit_sat_lo_flag", sat_lo, 1);

    drive(1, 1, 40, 20);
    drive(1, 1, 40, 22);
    saw_dv = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      if (duty_valid) saw_dv = 1;
    end
    check("lit_en_drop_no_dv", saw_dv, 0);
    check("lit_en_drop_duty", duty, 76);

    sample_and_wait(35, 0);
    drive(1, 1, 30, 10);
    drive(1, 1, 30, 12);
    @(negedge clk_20Hz);
    rst = 1'b1;
    @(negedge clk_20Hz);
    check("lit_midrst_duty", duty, 76);
    check("lit_midrst_dv", duty_valid, 0);
    check("lit_midrst_sat_hi", sat_hi, 0);
    rst = 1'b0;

    gap = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_20Hz);
      r = $urandom_range(0, 999);
      rst = (r < 6);
      enable = ($urandom_range(0, 99) >= 3);
      if (gap > 0) begin
        gap--;
        meas_valid = 1'b0;
      end else if (r >= 980) begin
        gap = $urandom_range(5, 14);
        meas_valid = 1'b0;
      end else begin
        meas_valid = ($urandom_range(0, 99) < 70);
      end
      setpoint = 6'($urandom);
      if ($urandom_range(0, 3) == 0)
        meas = 6'(int'(setpoint) + $urandom_range(0, 4) - 2);
      else
        meas = 6'($urandom);
    end
    rst = 1'b0;
    meas_valid = 1'b0;
    repeat (4) @(negedge clk_20Hz);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
